// File: rtl/core_pkg.sv
// Shared types and TOY opcode classification helpers for the issue window.
package core_pkg;

    localparam int PC_MAX_W = 32;

    typedef enum logic [3:0] {
        OP_HALT = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHL  = 4'h5,
        OP_SHR  = 4'h6,
        OP_LDA  = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_BZ   = 4'hC,
        OP_BP   = 4'hD,
        OP_JR   = 4'hE,
        OP_JL   = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_JUMP_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } state_e;

    // pc is stored at a fixed maximum width; the window truncates to PC_W.
    typedef struct packed {
        logic [15:0]         instr;
        logic [PC_MAX_W-1:0] pc;
    } win_entry_t;

    function automatic logic [15:0] reg_bit(input logic [3:0] r);
        logic [15:0] m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    // R0 is excluded so it can never raise a source hazard.
    function automatic logic [15:0] src_mask(input logic [15:0] instr);
        logic [15:0] m;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        rd = instr[11:8];
        rs = instr[7:4];
        rt = instr[3:0];
        case (op_e'(instr[15:12]))
            OP_ADD, OP_SUB, OP_AND,
            OP_XOR, OP_SHL, OP_SHR: m = reg_bit(rs) | reg_bit(rt);
            OP_ST:                  m = reg_bit(rd);
            OP_LDI:                 m = reg_bit(rt);
            OP_STI:                 m = reg_bit(rd) | reg_bit(rt);
            OP_BZ, OP_BP, OP_JR:    m = reg_bit(rd);
            default:                m = '0;
        endcase
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic writes_rd(input op_e op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHL, OP_SHR,
            OP_LDA, OP_LD, OP_LDI, OP_JL: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input op_e op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input op_e op);
        return (op == OP_BZ) || (op == OP_BP) || (op == OP_JR) || (op == OP_JL);
    endfunction

endpackage

// File: rtl/core_issue_slot_check.sv
// One lane of the in-order issue scan; lanes are chained oldest to youngest.
module core_issue_slot_check
    import core_pkg::*;
(
    input  logic [15:0] instr,
    input  logic [15:0] scoreboard,
    input  logic [15:0] rd_mask_prev,
    input  logic        mem_prev,
    input  logic        ctrl_prev,
    input  logic        lsu_busy,
    input  logic        first_lane,
    input  logic        prev_ok,
    output logic        ok,
    output logic [15:0] rd_mask,
    output logic        mem_seen,
    output logic        ctrl_seen
);
    op_e        op;
    logic [3:0] rd;
    logic       writer;
    logic       mem;
    logic       ctrl;
    logic       halt;
    logic       src_hz;
    logic       waw_hz;
    logic       mem_hz;
    logic       halt_hz;

    assign op     = op_e'(instr[15:12]);
    assign rd     = instr[11:8];
    assign writer = writes_rd(op) && (rd != 4'd0);
    assign mem    = is_mem(op);
    assign ctrl   = is_ctrl(op);
    assign halt   = (op == OP_HALT);

    assign src_hz  = |(src_mask(instr) & (scoreboard | rd_mask_prev));
    assign waw_hz  = writer && scoreboard[rd];
    assign mem_hz  = mem && (lsu_busy || mem_prev);
    assign halt_hz = halt && (!first_lane || (|scoreboard) || lsu_busy);

    assign ok = prev_ok && !src_hz && !waw_hz && !mem_hz && !ctrl_prev && !halt_hz;

    // Youngest-lane flags accumulate whether or not this lane issues; once a
    // lane fails, every later lane is already blocked through prev_ok.
    assign rd_mask   = rd_mask_prev | (writer ? reg_bit(rd) : 16'h0000);
    assign mem_seen  = mem_prev | mem;
    assign ctrl_seen = ctrl_prev | ctrl | halt;

endmodule

// File: rtl/core_issue_window.sv
// DEPTH-entry in-order issue window with scoreboard, issuing up to ISSUE_W per cycle.
// Optional CORE_ISSUE_BYPASS_EN: same-cycle writeback counts as clean in the hazard scan.
module core_issue_window
    import core_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ISSUE_W = 2,
    parameter int PC_W    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    fetch_valid_i,
    input  logic [15:0]             fetch_instr_i,
    input  logic [PC_W-1:0]         fetch_pc_i,
    output logic                    fetch_ready_o,
    output logic [ISSUE_W-1:0]      issue_valid_o,
    output logic [ISSUE_W*16-1:0]   issue_instr_o,
    output logic [ISSUE_W*PC_W-1:0] issue_pc_o,
    input  logic                    issue_ready_i,
    input  logic                    wb_valid_i,
    input  logic [3:0]              wb_rd_i,
    input  logic                    lsu_busy_i,
    input  logic                    redirect_i,
    input  logic                    redirect_taken_i,
    output logic                    halted_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e     state;
    state_e     state_next;
    win_entry_t win [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] deq_n;
    logic [15:0]      sb;
    logic [15:0]      sb_next;
    logic [15:0]      scan_sb;
    logic [15:0]      wb_mask;
    logic [15:0]      set_mask;
    logic             run_en;
    logic             accept;
    logic             enq;
    logic             flush;
    logic             go_jump;
    logic             go_halt;

    logic [ISSUE_W-1:0][PTR_W-1:0] lane_idx;
    logic [ISSUE_W-1:0][15:0]      lane_instr;
    logic [ISSUE_W-1:0][PC_W-1:0]  lane_pc;
    logic [ISSUE_W-1:0]            lane_present;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    always_comb begin
        wb_mask = '0;
        if (wb_valid_i) wb_mask[wb_rd_i] = 1'b1;
    end

`ifdef CORE_ISSUE_BYPASS_EN
    assign scan_sb = sb & ~wb_mask;
`else
    assign scan_sb = sb;
`endif

    assign run_en = (state == ST_RUN) && !rst_i;

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            lane_idx[k]     = ptr_add(head, k);
            lane_instr[k]   = win[lane_idx[k]].instr;
            lane_pc[k]      = win[lane_idx[k]].pc[PC_W-1:0];
            lane_present[k] = (CNT_W'(k) < count);
        end
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
        logic        prev_ok;
        logic [15:0] prev_rd;
        logic        prev_mem;
        logic        prev_ctrl;
        logic        ok;
        logic [15:0] rd_mask;
        logic        mem_seen;
        logic        ctrl_seen;

        if (k == 0) begin : g_first
            assign prev_ok   = run_en;
            assign prev_rd   = '0;
            assign prev_mem  = 1'b0;
            assign prev_ctrl = 1'b0;
        end else begin : g_next
            assign prev_ok   = g_lane[k-1].ok;
            assign prev_rd   = g_lane[k-1].rd_mask;
            assign prev_mem  = g_lane[k-1].mem_seen;
            assign prev_ctrl = g_lane[k-1].ctrl_seen;
        end

        core_issue_slot_check u_check (
            .instr        (lane_instr[k]),
            .scoreboard   (scan_sb),
            .rd_mask_prev (prev_rd),
            .mem_prev     (prev_mem),
            .ctrl_prev    (prev_ctrl),
            .lsu_busy     (lsu_busy_i),
            .first_lane   ((k == 0) ? 1'b1 : 1'b0),
            .prev_ok      (prev_ok && lane_present[k]),
            .ok           (ok),
            .rd_mask      (rd_mask),
            .mem_seen     (mem_seen),
            .ctrl_seen    (ctrl_seen)
        );

        assign issue_valid_o[k] = ok;
    end

    assign issue_instr_o = lane_instr;
    assign issue_pc_o    = lane_pc;
    assign accept        = issue_ready_i && issue_valid_o[0];
    assign enq           = fetch_valid_i && fetch_ready_o;

    // Effects of the group leaving on the accept edge.
    always_comb begin
        deq_n    = '0;
        set_mask = '0;
        go_jump  = 1'b0;
        go_halt  = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (accept && issue_valid_o[k]) begin
                deq_n = deq_n + CNT_W'(1);
                if (writes_rd(op_e'(lane_instr[k][15:12])) && (lane_instr[k][11:8] != 4'd0))
                    set_mask[lane_instr[k][11:8]] = 1'b1;
                if (is_ctrl(op_e'(lane_instr[k][15:12]))) go_jump = 1'b1;
                if (op_e'(lane_instr[k][15:12]) == OP_HALT) go_halt = 1'b1;
            end
        end
    end

    // A set and a clear of the same bit on one edge: the new writer wins.
    always_comb begin
        sb_next    = (sb & ~wb_mask) | set_mask;
        sb_next[0] = 1'b0;
        count_next = count + (enq ? CNT_W'(1) : CNT_W'(0)) - deq_n;
    end

    always_comb begin
        state_next    = state;
        flush         = 1'b0;
        fetch_ready_o = 1'b0;
        halted_o      = 1'b0;
        if (!rst_i) begin
            case (state)
                ST_RUN: begin
                    fetch_ready_o = (count < CNT_W'(DEPTH));
                    if (go_halt)      state_next = ST_HALTED;
                    else if (go_jump) state_next = ST_JUMP_WAIT;
                end
                ST_JUMP_WAIT: begin
                    if (redirect_i) begin
                        state_next = ST_RUN;
                        flush      = redirect_taken_i;
                    end
                end
                ST_HALTED: halted_o = 1'b1;
                default:   state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            sb    <= '0;
        end else begin
            state <= state_next;
            sb    <= sb_next;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (accept) head <= ptr_add(head, int'(deq_n));
                if (enq)    tail <= ptr_add(tail, 1);
                count <= count_next;
            end
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            win[tail].instr <= fetch_instr_i;
            win[tail].pc    <= PC_MAX_W'(fetch_pc_i);
        end
    end

endmodule

// File: tb/tb_core_issue_window.sv
// Directed bench for core_issue_window (DEPTH=4, ISSUE_W=2, PC_W=8).
module tb_core_issue_window;
    localparam int DEPTH   = 4;
    localparam int ISSUE_W = 2;
    localparam int PC_W    = 8;

`ifdef CORE_ISSUE_BYPASS_EN
    localparam logic [1:0] BYP_V = 2'b01;
`else
    localparam logic [1:0] BYP_V = 2'b00;
`endif

    logic                    clk = 1'b0;
    logic                    rst_i;
    logic                    fetch_valid_i;
    logic [15:0]             fetch_instr_i;
    logic [PC_W-1:0]         fetch_pc_i;
    logic                    fetch_ready_o;
    logic [ISSUE_W-1:0]      issue_valid_o;
    logic [ISSUE_W*16-1:0]   issue_instr_o;
    logic [ISSUE_W*PC_W-1:0] issue_pc_o;
    logic                    issue_ready_i;
    logic                    wb_valid_i;
    logic [3:0]              wb_rd_i;
    logic                    lsu_busy_i;
    logic                    redirect_i;
    logic                    redirect_taken_i;
    logic                    halted_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_issue_window #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .PC_W(PC_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_instr_i    (fetch_instr_i),
        .fetch_pc_i       (fetch_pc_i),
        .fetch_ready_o    (fetch_ready_o),
        .issue_valid_o    (issue_valid_o),
        .issue_instr_o    (issue_instr_o),
        .issue_pc_o       (issue_pc_o),
        .issue_ready_i    (issue_ready_i),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_i          (wb_rd_i),
        .lsu_busy_i       (lsu_busy_i),
        .redirect_i       (redirect_i),
        .redirect_taken_i (redirect_taken_i),
        .halted_o         (halted_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fetch1(input logic [15:0] ins, input logic [7:0] pc);
        fetch_valid_i = 1'b1;
        fetch_instr_i = ins;
        fetch_pc_i    = pc;
        cyc();
        fetch_valid_i = 1'b0;
    endtask

    task automatic issue1();
        issue_ready_i = 1'b1;
        cyc();
        issue_ready_i = 1'b0;
    endtask

    task automatic wb1(input logic [3:0] r);
        wb_valid_i = 1'b1;
        wb_rd_i    = r;
        cyc();
        wb_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; fetch_valid_i = 1'b1; fetch_instr_i = 16'h1123; fetch_pc_i = 8'h00;
        issue_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = 4'd0; lsu_busy_i = 1'b0;
        redirect_i = 1'b0; redirect_taken_i = 1'b0;
        settle();
        chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd0);
        chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        cyc(); cyc();
        rst_i = 1'b0; fetch_valid_i = 1'b0;
        settle();
        chk("post_rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
        chk("post_rst_issue_valid", 32'(issue_valid_o), 32'd0);

        // Independent pair issues together.
        fetch1(16'h1123, 8'h10);
        fetch1(16'h2456, 8'h11);
        settle();
        chk("pair_valid", 32'(issue_valid_o), 32'h3);
        chk("pair_instr", 32'(issue_instr_o), 32'h2456_1123);
        chk("pair_pc", 32'(issue_pc_o), 32'h1110);
        cyc();
        chk("pair_stable", 32'(issue_valid_o), 32'h3);
        issue1();
        settle();
        chk("pair_drained", 32'(issue_valid_o), 32'd0);
        fetch1(16'h9100, 8'h12);
        settle();
        chk("r1_dirty", 32'(issue_valid_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_i = 4'd1;
        settle();
        chk("r1_wb_cycle", 32'(issue_valid_o), 32'(BYP_V));
        cyc(); wb_valid_i = 1'b0;
        settle();
        chk("r1_after_wb", 32'(issue_valid_o), 32'h1);
        issue1();
        fetch1(16'h9400, 8'h13);
        settle();
        chk("r4_dirty", 32'(issue_valid_o), 32'd0);
        wb1(4'd4);
        settle();
        chk("r4_after_wb", 32'(issue_valid_o), 32'h1);
        issue1();

        // RAW inside a group, then WAW, then R0 exemption.
        fetch1(16'h1123, 8'h20);
        fetch1(16'h2415, 8'h21);
        settle();
        chk("raw_group_valid", 32'(issue_valid_o), 32'h1);
        chk("raw_group_lane0", 32'(issue_instr_o[15:0]), 32'h1123);
        issue1();
        settle();
        chk("raw_blocked", 32'(issue_valid_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_i = 4'd1;
        settle();
        chk("raw_wb_cycle", 32'(issue_valid_o), 32'(BYP_V));
        cyc(); wb_valid_i = 1'b0;
        settle();
        chk("raw_after_wb", 32'(issue_valid_o), 32'h1);
        chk("raw_after_wb_instr", 32'(issue_instr_o[15:0]), 32'h2415);
        issue1();
        fetch1(16'h1400, 8'h22);
        settle();
        chk("waw_blocked", 32'(issue_valid_o), 32'd0);
        wb1(4'd4);
        settle();
        chk("waw_after_wb", 32'(issue_valid_o), 32'h1);
        issue1();
        wb1(4'd4);
        fetch1(16'h1000, 8'h23);
        fetch1(16'h1100, 8'h24);
        settle();
        chk("r0_exempt", 32'(issue_valid_o), 32'h3);
        issue1();
        wb1(4'd1);

        // One memory op per group; LSU busy blocks.
        fetch1(16'h8110, 8'h30);
        fetch1(16'h9220, 8'h31);
        settle();
        chk("mem_one_per_group", 32'(issue_valid_o), 32'h1);
        issue1();
        lsu_busy_i = 1'b1;
        settle();
        chk("mem_lsu_busy", 32'(issue_valid_o), 32'd0);
        lsu_busy_i = 1'b0;
        settle();
        chk("mem_lsu_free", 32'(issue_valid_o), 32'h1);
        chk("mem_lsu_free_instr", 32'(issue_instr_o[15:0]), 32'h9220);
        issue1();
        wb1(4'd1);

        // Control serialisation and redirect outcomes.
        fetch1(16'hC305, 8'h40);
        fetch1(16'h1111, 8'h41);
        settle();
        chk("ctrl_alone", 32'(issue_valid_o), 32'h1);
        issue1();
        settle();
        chk("jw_fetch_ready", 32'(fetch_ready_o), 32'd0);
        chk("jw_no_issue", 32'(issue_valid_o), 32'd0);
        redirect_i = 1'b1; redirect_taken_i = 1'b0;
        cyc(); redirect_i = 1'b0;
        settle();
        chk("nt_fetch_ready", 32'(fetch_ready_o), 32'd1);
        chk("nt_kept_valid", 32'(issue_valid_o), 32'h1);
        chk("nt_kept_instr", 32'(issue_instr_o[15:0]), 32'h1111);
        fetch1(16'hD300, 8'h42);
        fetch1(16'h7777, 8'h43);
        settle();
        chk("ctrl_lane1_valid", 32'(issue_valid_o), 32'h3);
        chk("ctrl_lane1_instr", 32'(issue_instr_o[31:16]), 32'hD300);
        issue1();
        redirect_i = 1'b1; redirect_taken_i = 1'b1;
        cyc(); redirect_i = 1'b0; redirect_taken_i = 1'b0;
        settle();
        chk("taken_flush_valid", 32'(issue_valid_o), 32'd0);
        chk("taken_fetch_ready", 32'(fetch_ready_o), 32'd1);
        wb1(4'd1);

        // Fill to DEPTH, hold the fifth, drain with pointer wrap.
        fetch1(16'h1123, 8'h21);
        fetch1(16'h2456, 8'h22);
        fetch1(16'h3789, 8'h23);
        settle();
        chk("full_ready_at_3", 32'(fetch_ready_o), 32'd1);
        fetch1(16'h4ABC, 8'h24);
        fetch_valid_i = 1'b1; fetch_instr_i = 16'h5DEF; fetch_pc_i = 8'h25;
        settle();
        chk("full_ready_at_4", 32'(fetch_ready_o), 32'd0);
        redirect_i = 1'b1; redirect_taken_i = 1'b1;
        cyc(); redirect_i = 1'b0; redirect_taken_i = 1'b0;
        settle();
        chk("full_redirect_ignored", 32'(issue_valid_o), 32'h3);
        chk("full_fifth_held", 32'(fetch_ready_o), 32'd0);
        issue_ready_i = 1'b1;
        settle();
        chk("full_no_passthru", 32'(fetch_ready_o), 32'd0);
        chk("drain1_instr", 32'(issue_instr_o), 32'h2456_1123);
        cyc();
        settle();
        chk("drain2_ready", 32'(fetch_ready_o), 32'd1);
        chk("drain2_instr", 32'(issue_instr_o), 32'h4ABC_3789);
        cyc();
        fetch_valid_i = 1'b0;
        settle();
        chk("wrap_valid", 32'(issue_valid_o), 32'h1);
        chk("wrap_instr", 32'(issue_instr_o[15:0]), 32'h5DEF);
        chk("wrap_pc", 32'(issue_pc_o[7:0]), 32'h25);
        cyc();
        issue_ready_i = 1'b0;
        settle();
        chk("wrap_drained", 32'(issue_valid_o), 32'd0);
        wb1(4'd1); wb1(4'd4); wb1(4'd7); wb1(4'hA); wb1(4'hD);

        // Halt waits for a clean scoreboard and lane 0.
        fetch1(16'h1500, 8'h50);
        fetch1(16'h0000, 8'h51);
        settle();
        chk("halt_not_lane1", 32'(issue_valid_o), 32'h1);
        issue1();
        settle();
        chk("halt_held_r5", 32'(issue_valid_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_i = 4'd5;
        settle();
        chk("halt_wb_cycle", 32'(issue_valid_o), 32'(BYP_V));
        cyc(); wb_valid_i = 1'b0;
        settle();
        chk("halt_ready", 32'(issue_valid_o), 32'h1);
        chk("halt_instr", 32'(issue_instr_o[15:0]), 32'h0000);
        issue1();
        settle();
        chk("halted_set", 32'(halted_o), 32'd1);
        chk("halted_fetch_ready", 32'(fetch_ready_o), 32'd0);
        fetch_valid_i = 1'b1; fetch_instr_i = 16'h1123; redirect_i = 1'b1; redirect_taken_i = 1'b1;
        cyc(); cyc();
        fetch_valid_i = 1'b0; redirect_i = 1'b0; redirect_taken_i = 1'b0;
        settle();
        chk("halted_persists", 32'(halted_o), 32'd1);
        chk("halted_no_issue", 32'(issue_valid_o), 32'd0);
        rst_i = 1'b1;
        settle();
        chk("halt_rst_halted", 32'(halted_o), 32'd0);
        cyc();
        rst_i = 1'b0;
        settle();
        chk("halt_cleared", 32'(halted_o), 32'd0);
        chk("halt_cleared_ready", 32'(fetch_ready_o), 32'd1);
        chk("halt_cleared_empty", 32'(issue_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_issue_window.md
Name: core_issue_window

Overview:
- Parametrised successor to the single-slot TOY decoder: a DEPTH-entry in-order instruction window with a registered 16-entry scoreboard, issuing up to ISSUE_W instructions per cycle.
- Sits between fetch and the ALU/LSU/branch lanes.
- Owns RAW/WAW hazard tracking, the one-memory-op-per-group rule, control-flow serialisation and the halt state.

Parameters:
- DEPTH, 4, number of window entries (>=2)
- ISSUE_W, 2, maximum instructions issued per cycle (1..DEPTH)
- PC_W, 8, program-counter width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- fetch_valid_i  in  1  fetch offers an instruction
- fetch_instr_i  in  16  TOY instruction: op[15:12] rd[11:8] rs[7:4] rt[3:0]
- fetch_pc_i  in  PC_W  PC of the offered instruction
- fetch_ready_o  out  1  window accepts the offered instruction this cycle
- issue_valid_o  out  ISSUE_W  per-lane issue valid; always a contiguous prefix from lane 0
- issue_instr_o  out  ISSUE_W*16  per-lane instruction; lane 0 is the oldest
- issue_pc_o  out  ISSUE_W*PC_W  per-lane PC
- issue_ready_i  in  1  backend consumes every valid lane this cycle (all-or-nothing)
- wb_valid_i  in  1  register writeback completes
- wb_rd_i  in  4  register index written back
- lsu_busy_i  in  1  LSU has an outstanding access
- redirect_i  in  1  control instruction resolved
- redirect_taken_i  in  1  qualifies redirect_i: the resolved control transfer was taken
- halted_o  out  1  core halted

Behaviour:
- Reset: window empty; scoreboard all clear; state RUN. While rst_i is high, fetch_ready_o=0, issue_valid_o=0 and halted_o=0. Reset mid-group or mid-JUMP_WAIT discards everything.
- Buffer:
  - Circular FIFO with occupancy count of width $clog2(DEPTH+1).
  - fetch_ready_o = (state==RUN) && (count<DEPTH). There is no pass-through when full, even if issue drains in the same cycle.
  - At most one enqueue per cycle; an entry enqueued at edge t is issuable from cycle t+1.
  - Head and tail pointers wrap modulo DEPTH.
- Per-opcode classification:
  - Sources: 1-6 read rs,rt; 9 reads rd; A reads rt; B reads rd,rt; C/D/E read rd.
  - Writers: 1-8, A and F write rd.
  - Memory ops: 8, 9, A, B. Control ops: C, D, E, F. Halt: 0.
- Issue scan runs over the oldest min(count, ISSUE_W) entries, in order. Lane k is valid only if lane k-1 is valid and none of the following hold:
  - a source register is dirty in the scoreboard or is the rd of a writer in an earlier lane;
  - the writer's rd is dirty (WAW);
  - it is a memory op and either lsu_busy_i=1 or an earlier lane is a memory op;
  - an earlier lane is a control op or a halt;
  - it is a halt and k!=0 or any scoreboard bit is set or lsu_busy_i=1.
  - R0 is never dirty, and is never a hazard as a source.
- Issue outputs are combinational from the window head. With issue_ready_i=0 the outputs stay stable and the state is unchanged.
- On the accept edge (issue_ready_i && issue_valid_o[0]):
  - dequeue all valid lanes;
  - set the dirty bit for each writer with rd!=0;
  - an issued control op moves state to JUMP_WAIT;
  - an issued halt moves state to HALTED.
- Scoreboard update: wb_valid_i clears bit wb_rd_i. If a set and a clear hit the same bit on the same edge, the set wins.
- State machine RUN / JUMP_WAIT / HALTED:
  - JUMP_WAIT: no issue, fetch_ready_o=0. redirect_i with redirect_taken_i=1 flushes the window (count=0) and returns to RUN; with redirect_taken_i=0 it keeps the window and returns to RUN.
  - redirect_i is ignored in RUN and in HALTED.
  - HALTED: halted_o=1, no fetch, no issue; exit only via rst_i. Writebacks still clear scoreboard bits.

Optional Feature:
- Macro CORE_ISSUE_BYPASS_EN.
- Defined: a same-cycle wb_valid_i/wb_rd_i is treated as already clear in the hazard scan, so a dependent can issue in the writeback cycle.
- Undefined: the scan uses the registered scoreboard only, so a dependent issues no earlier than the cycle after writeback.

Decomposition:
- Package core_pkg holds:
  - enum op_e for the 16 opcodes;
  - functions src_mask(instr) returning a 16-bit mask, writes_rd(op), is_mem(op), is_ctrl(op);
  - typedef win_entry_t {instr, pc}.
- Sub-module core_issue_slot_check: combinational per-lane hazard check taking instr, scoreboard, earlier-lane rd mask / mem / ctrl flags and lsu_busy; produces ok plus the updated masks. Instantiated ISSUE_W times as a chain.

Test Plan:
- Independent pair, no bypass: 0x1123 then 0x2456, issue_ready_i=1 -> both lanes valid in one cycle; dirty bits 1 and 4 set on the accept edge.
- RAW in group: 0x1123 then 0x2415 -> lane0 only; 0x2415 issues in the cycle after wb_rd_i=1 (in the same cycle with CORE_ISSUE_BYPASS_EN defined).
- Memory: 0x8110 then 0x9220 with lsu_busy_i=0 -> lane0 only (one memory op per group); 0x9220 waits until lsu_busy_i=0 and r2 is clean.
- Control: 0xC305 with r3 clean -> issues, fetch_ready_o drops. redirect_i=1, redirect_taken_i=1 -> window count=0, RUN. With redirect_taken_i=0 -> queued entries are kept.
- Full: DEPTH=4, issue_ready_i=0, five fetches offered -> fourth accepted, fifth held with fetch_ready_o=0; pointers wrap correctly after drain.
- Halt: 0x0000 behind an outstanding write to r5 -> held until wb_rd_i=5, then issues; halted_o=1 persists until rst_i clears it to 0 and restores fetch_ready_o=1.
